alu_cmd_unit: RTL and testbench

ALU_CMD_UNIT -- requirements
Module: alu_cmd_unit

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_cmd_unit_sat_counter.sv | 26 ++
 rtl/alu_cmd_unit.sv | 156 +++++++++++++++
 tb/tb_alu_cmd_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU command unit: opcode constants, the
// invalid-opcode check and the control FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_LESS = 3'd1;
  localparam logic [2:0] OP_EQ   = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes 6 and 7 have no ALU operation behind them.
  function automatic logic is_invalid_op(input logic [2:0] op);
    return (op > OP_NOT);
  endfunction

endpackage

// File: rtl/alu_cmd_unit_sat_counter.sv
// sat_counter
// 16-bit event counter that sticks at all-ones instead of wrapping.
//   clk      : rising-edge clock
//   i_clr    : synchronous clear, wins over i_inc
//   i_inc    : count one event this cycle
//   o_count  : current count
module sat_counter (
  input  logic        clk,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_unit.sv
// alu_cmd_unit
// Accepts one command at a time, hands opcode/operands to an external
// combinational ALU, captures its result after one cycle and offers it as a
// tagged response. Invalid opcodes return zero with the error flag set.
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_opcode/cmd_a/cmd_b/cmd_tag: command fields
//   alu_opcode/alu_op_a/alu_op_b  : held operands to the external ALU
//   alu_result                    : external ALU result
//   rsp_valid/rsp_ready           : response handshake
//   rsp_result/rsp_tag/rsp_err    : response fields
//   op_count/err_count            : saturating response / error-response counts
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | ALU evaluating the latched command (one cycle)
// RESP  | response offered, held until rsp_ready
module alu_cmd_unit
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alu_opcode,
  output logic [N-1:0]     alu_op_a,
  output logic [N-1:0]     alu_op_b,
  input  logic [N-1:0]     alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      op_count,
  output logic [15:0]      err_count
);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic             w_cmd_ready_nxt;
  logic             w_rsp_valid_nxt;
  logic [2:0]       r_alu_opcode;
  logic [N-1:0]     r_alu_op_a;
  logic [N-1:0]     r_alu_op_b;
  logic [TAG_W-1:0] r_tag;
  logic [N-1:0]     r_rsp_result;
  logic             r_rsp_err;

  logic w_accept;
  logic w_exec_done;
  logic w_rsp_fire;

  assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
  assign w_exec_done = (r_state == ST_EXEC);
  assign w_rsp_fire  = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE: w_cmd_ready_nxt = 1'b1;
      ST_RESP: w_rsp_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_opcode <= '0;
      r_alu_op_a   <= '0;
      r_alu_op_b   <= '0;
      r_tag        <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_opcode <= cmd_opcode;
        r_alu_op_a   <= cmd_a;
        r_alu_op_b   <= cmd_b;
        r_tag        <= cmd_tag;
      end
      if (w_exec_done) begin
        if (is_invalid_op(r_alu_opcode)) begin
          r_rsp_result <= '0;
          r_rsp_err    <= 1'b1;
        end else begin
          r_rsp_result <= alu_result;
          r_rsp_err    <= 1'b0;
        end
      end
    end
  end

  sat_counter u_op_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_inc   (w_rsp_fire),
    .o_count (op_count)
  );

  sat_counter u_err_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_inc   (w_rsp_fire && r_rsp_err),
    .o_count (err_count)
  );

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign alu_opcode = r_alu_opcode;
  assign alu_op_a   = r_alu_op_a;
  assign alu_op_b   = r_alu_op_b;
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_tag;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_unit.sv
// tb_alu_cmd_unit
// Self-checking bench: acts as the external ALU, applies a vector table,
// hand-written multi-cycle sequences and random commands, and checks
// saturation on a standalone counter instance.
module tb_alu_cmd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [15:0] op_count;
  logic [15:0] err_count;

  logic        sat_clr;
  logic        sat_inc;
  logic [15:0] sat_count;

  int vectors    = 0;
  int miscompares = 0;
  int exp_ops    = 0;
  int exp_errs   = 0;

  always #5 clk = ~clk;

  alu_cmd_unit #(.N(32), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_opcode (alu_opcode),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .op_count   (op_count),
    .err_count  (err_count)
  );

  sat_counter u_sat (
    .clk     (clk),
    .i_clr   (sat_clr),
    .i_inc   (sat_inc),
    .o_count (sat_count)
  );

  // External ALU; invalid opcodes return junk that the unit must suppress.
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return (a < b) ? 32'd1 : 32'd0;
      3'd2:    return (a == b) ? 32'd1 : 32'd0;
      3'd3:    return a | b;
      3'd4:    return a & b;
      3'd5:    return ~a;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] exp_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op >= 3'd6) ? 32'd0 : alu_f(op, a, b);
  endfunction

  always_comb alu_result = alu_f(alu_opcode, alu_op_a, alu_op_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat_inc16(input int v);
    return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
  endfunction

  // Called on a falling edge; returns on a falling edge after the handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input int stall,
                         input logic [31:0] exp_res, input logic exp_err);
    int n;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    cmd_valid  = 1'b1;
    rsp_ready  = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: cmd_ready never rose");
    end
    @(negedge clk);
    // Keep offering a different command; it must be ignored until IDLE.
    cmd_opcode = ~op; cmd_a = ~a; cmd_b = ~b; cmd_tag = ~tag;
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_cmd_ready", cmd_ready, 0);
    chk("alu_opcode", alu_opcode, op);
    chk("alu_op_a", alu_op_a, a);
    chk("alu_op_b", alu_op_b, b);
    @(negedge clk);
    chk("latency_rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_tag", rsp_tag, tag);
    chk("rsp_err", rsp_err, exp_err);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_result", rsp_result, exp_res);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_op_count", op_count, exp_ops);
      chk("stall_alu_op_a", alu_op_a, a);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops = sat_inc16(exp_ops);
    if (exp_err) exp_errs = sat_inc16(exp_errs);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("op_count", op_count, exp_ops);
    chk("err_count", err_count, exp_errs);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    int          stall;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{3'd0, 32'd10,         32'd20,         4'd3,  0, 32'd30,         1'b0};
    vt[1] = '{3'd1, 32'd15,         32'd20,         4'd1,  5, 32'd1,          1'b0};
    vt[2] = '{3'd7, 32'h0F,         32'd0,          4'd2,  0, 32'd0,          1'b1};
    vt[3] = '{3'd2, 32'd5,          32'd5,          4'd4,  1, 32'd1,          1'b0};
    vt[4] = '{3'd2, 32'd5,          32'd6,          4'd5,  0, 32'd0,          1'b0};
    vt[5] = '{3'd4, 32'h0000_F0F0,  32'h0000_FF00,  4'd6,  2, 32'h0000_F000,  1'b0};
    vt[6] = '{3'd0, 32'hFFFF_FFFF,  32'd1,          4'd7,  0, 32'd0,          1'b0};
    vt[7] = '{3'd1, 32'd20,         32'd15,         4'd8,  0, 32'd0,          1'b0};
    vt[8] = '{3'd6, 32'h1234,       32'h5678,       4'd9,  3, 32'd0,          1'b1};
    vt[9] = '{3'd5, 32'd0,          32'd0,          4'hF,  0, 32'hFFFF_FFFF,  1'b0};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    sat_clr = 1'b1; sat_inc = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 10; i++)
      run_cmd(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].stall, vt[i].exp_res, vt[i].exp_err);

    // Back-to-back with cmd_valid held: NOT then OR, accepted 3 cycles apart.
    cmd_opcode = 3'd5; cmd_a = 32'h0F; cmd_b = 32'd0; cmd_tag = 4'd5;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_first_opcode", alu_opcode, 3'd5);
    cmd_opcode = 3'd3; cmd_a = 32'h0F; cmd_b = 32'hF0; cmd_tag = 4'd6;
    @(negedge clk);
    chk("b2b_first_valid", rsp_valid, 1);
    chk("b2b_first_result", rsp_result, 32'hFFFF_FFF0);
    chk("b2b_first_tag", rsp_tag, 4'd5);
    exp_ops = sat_inc16(exp_ops);
    @(negedge clk);
    chk("b2b_gap_cmd_ready", cmd_ready, 1);
    chk("b2b_gap_rsp_valid", rsp_valid, 0);
    chk("b2b_gap_opcode_held", alu_opcode, 3'd5);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_opcode", alu_opcode, 3'd3);
    chk("b2b_second_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("b2b_second_result", rsp_result, 32'h0000_00FF);
    chk("b2b_second_tag", rsp_tag, 4'd6);
    exp_ops = sat_inc16(exp_ops);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_op_count", op_count, exp_ops);

    // Reset while a response is pending.
    cmd_opcode = 3'd0; cmd_a = 32'd7; cmd_b = 32'd8; cmd_tag = 4'd2;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    rst = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0; exp_errs = 0;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_alu_op_a", alu_op_a, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("dropped_rsp_valid", rsp_valid, 0);
    chk("dropped_op_count", op_count, 0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_cmd(op, a, b, 4'($urandom), int'($urandom_range(0, 3)), exp_result(op, a, b), op >= 3'd6);
    end

    // Counter saturation on a standalone instance.
    sat_clr = 1'b0; sat_inc = 1'b1;
    repeat (65534) @(negedge clk);
    chk("sat_fffe", sat_count, 16'hFFFE);
    repeat (3) @(negedge clk);
    chk("sat_ffff", sat_count, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("sat_hold", sat_count, 16'hFFFF);
    sat_clr = 1'b1;
    @(negedge clk);
    chk("sat_clr_priority", sat_count, 16'h0000);
    sat_clr = 1'b0; sat_inc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
